// File: rtl/me_pkg.sv
// Shared constants and types for the basic-layer motion-estimation engine.
// SAD widths grow one bit per partition doubling, so no sum can overflow.
package me_pkg;
    localparam int PIXEL_W     = 8;
    localparam int BLK         = 32;
    localparam int ROW_W       = BLK * PIXEL_W;
    localparam int SAD4X4_W    = 12;
    localparam int SAD4X8_W    = 13;
    localparam int SAD8X8_W    = 14;
    localparam int SAD8X16_W   = 15;
    localparam int SAD16X16_W  = 16;
    localparam int SAD16X32_W  = 17;
    localparam int SAD32X32_W  = 18;
    localparam int ROW_MAX     = 95;
    localparam int COL_MAX     = 31;
    localparam int LOAD_PAIRS  = 16;

    typedef enum logic {
        LD_IDLE = 1'b0,
        LD_LOAD = 1'b1
    } load_state_e;

    typedef logic [ROW_W-1:0] row_t;
endpackage

// File: rtl/sad4x4_pe.sv
// Combinational SAD of one 4x4 block: 16 pixel pairs in, 12-bit sum out.
module sad4x4_pe
    import me_pkg::*;
(
    input  logic [16*PIXEL_W-1:0] cur_pix,
    input  logic [16*PIXEL_W-1:0] ref_pix,
    output logic [SAD4X4_W-1:0]   sad
);
    function automatic logic [PIXEL_W-1:0] abs_diff(input logic [PIXEL_W-1:0] a,
                                                    input logic [PIXEL_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    always_comb begin
        sad = '0;
        for (int i = 0; i < 16; i++) begin
            sad = sad + SAD4X4_W'(abs_diff(cur_pix[i*PIXEL_W +: PIXEL_W],
                                           ref_pix[i*PIXEL_W +: PIXEL_W]));
        end
    end
endmodule

// File: rtl/basic_layer_search_engine.sv
// Integer ME engine: current-block loader, 32-row reference window and a
// registered hierarchical SAD tree covering every partition from 4x8 to 32x32.
module basic_layer_search_engine
    import me_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] ref_input,
    input  logic [511:0] current_64pixels,
    input  logic         ref_begin_prepare,
    input  logic         pe_begin_prepare,
    output logic [415:0] SAD4x8,
    output logic [415:0] SAD8x4,
    output logic [223:0] SAD8x8,
    output logic [119:0] SAD8x16,
    output logic [119:0] SAD16x8,
    output logic [63:0]  SAD16x16,
    output logic [33:0]  SAD16x32,
    output logic [33:0]  SAD32x16,
    output logic [17:0]  SAD32x32,
    output logic [4:0]   search_column_count,
    output logic [6:0]   search_row_count
);
    load_state_e state_q, state_d;
    logic [3:0]  load_idx_q, load_idx_d;
    logic        pe_prev_q;
    logic        load_en;
    row_t        cur_buf_q [BLK];
    row_t        cur_buf_d [BLK];
    row_t        ref_buf_q [BLK];
    row_t        ref_buf_d [BLK];
    logic [6:0]  row_cnt_q, row_cnt_d;
    logic [4:0]  col_cnt_q, col_cnt_d;

    logic [415:0] sad4x8_q, sad4x8_d, sad8x4_q, sad8x4_d;
    logic [223:0] sad8x8_q, sad8x8_d;
    logic [119:0] sad8x16_q, sad8x16_d, sad16x8_q, sad16x8_d;
    logic [63:0]  sad16x16_q, sad16x16_d;
    logic [33:0]  sad16x32_q, sad16x32_d, sad32x16_q, sad32x16_d;
    logic [17:0]  sad32x32_q, sad32x32_d;

    logic [SAD4X4_W-1:0]   s44   [64];
    logic [SAD4X8_W-1:0]   s48   [32];
    logic [SAD4X8_W-1:0]   s84   [32];
    logic [SAD8X8_W-1:0]   s88   [16];
    logic [SAD8X16_W-1:0]  s816  [8];
    logic [SAD8X16_W-1:0]  s168  [8];
    logic [SAD16X16_W-1:0] s1616 [4];
    logic [SAD16X32_W-1:0] s1632 [2];
    logic [SAD16X32_W-1:0] s3216 [2];

    // Load FSM: the detecting cycle already writes pair 0, LOAD writes pairs 1..15.
    always_comb begin
        state_d    = state_q;
        load_idx_d = load_idx_q;
        load_en    = 1'b0;
        case (state_q)
            LD_IDLE: begin
                if (pe_begin_prepare && !pe_prev_q) begin
                    load_en    = 1'b1;
                    load_idx_d = 4'd1;
                    state_d    = LD_LOAD;
                end
            end
            LD_LOAD: begin
                load_en = 1'b1;
                if (load_idx_q == 4'(LOAD_PAIRS - 1)) begin
                    load_idx_d = '0;
                    state_d    = LD_IDLE;
                end else begin
                    load_idx_d = load_idx_q + 4'd1;
                end
            end
        endcase
    end

    always_comb begin
        cur_buf_d = cur_buf_q;
        ref_buf_d = ref_buf_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        if (load_en) begin
            cur_buf_d[{load_idx_q, 1'b0}] = current_64pixels[ROW_W-1:0];
            cur_buf_d[{load_idx_q, 1'b1}] = current_64pixels[2*ROW_W-1:ROW_W];
        end
        if (ref_begin_prepare) begin
            for (int k = 0; k < BLK - 1; k++) ref_buf_d[k] = ref_buf_q[k+1];
            ref_buf_d[BLK-1] = ref_input;
            if (row_cnt_q == 7'(ROW_MAX)) begin
                row_cnt_d = '0;
                col_cnt_d = (col_cnt_q == 5'(COL_MAX)) ? '0 : col_cnt_q + 5'd1;
            end else begin
                row_cnt_d = row_cnt_q + 7'd1;
            end
        end
    end

    for (genvar by = 0; by < 8; by++) begin : g_row
        for (genvar bx = 0; bx < 8; bx++) begin : g_col
            sad4x4_pe u_pe (
                .cur_pix ({cur_buf_q[4*by+3][4*PIXEL_W*bx +: 4*PIXEL_W],
                           cur_buf_q[4*by+2][4*PIXEL_W*bx +: 4*PIXEL_W],
                           cur_buf_q[4*by+1][4*PIXEL_W*bx +: 4*PIXEL_W],
                           cur_buf_q[4*by  ][4*PIXEL_W*bx +: 4*PIXEL_W]}),
                .ref_pix ({ref_buf_q[4*by+3][4*PIXEL_W*bx +: 4*PIXEL_W],
                           ref_buf_q[4*by+2][4*PIXEL_W*bx +: 4*PIXEL_W],
                           ref_buf_q[4*by+1][4*PIXEL_W*bx +: 4*PIXEL_W],
                           ref_buf_q[4*by  ][4*PIXEL_W*bx +: 4*PIXEL_W]}),
                .sad     (s44[by*8+bx])
            );
        end
    end

    // Combining tree; 4x4 results are indexed by (4-row band)*8 + (4-px column).
    always_comb begin
        s48 = '{default: '0};  s84 = '{default: '0};  s88 = '{default: '0};
        s816 = '{default: '0}; s168 = '{default: '0}; s1616 = '{default: '0};
        s1632 = '{default: '0}; s3216 = '{default: '0};
        sad4x8_d = '0; sad8x4_d = '0; sad8x8_d = '0; sad8x16_d = '0; sad16x8_d = '0;
        sad16x16_d = '0; sad16x32_d = '0; sad32x16_d = '0;
        for (int i = 0; i < 32; i++) begin
            s48[i] = SAD4X8_W'(s44[(i/8)*16 + i%8]) + SAD4X8_W'(s44[(i/8)*16 + 8 + i%8]);
            s84[i] = SAD4X8_W'(s44[(i/4)*8 + 2*(i%4)]) + SAD4X8_W'(s44[(i/4)*8 + 2*(i%4) + 1]);
            sad4x8_d[SAD4X8_W*i +: SAD4X8_W] = s48[i];
            sad8x4_d[SAD4X8_W*i +: SAD4X8_W] = s84[i];
        end
        for (int i = 0; i < 16; i++) begin
            s88[i] = SAD8X8_W'(s48[(i/4)*8 + 2*(i%4)]) + SAD8X8_W'(s48[(i/4)*8 + 2*(i%4) + 1]);
            sad8x8_d[SAD8X8_W*i +: SAD8X8_W] = s88[i];
        end
        for (int i = 0; i < 8; i++) begin
            s816[i] = SAD8X16_W'(s88[(i/4)*8 + i%4]) + SAD8X16_W'(s88[(i/4)*8 + 4 + i%4]);
            s168[i] = SAD8X16_W'(s88[(i/2)*4 + 2*(i%2)]) + SAD8X16_W'(s88[(i/2)*4 + 2*(i%2) + 1]);
            sad8x16_d[SAD8X16_W*i +: SAD8X16_W] = s816[i];
            sad16x8_d[SAD8X16_W*i +: SAD8X16_W] = s168[i];
        end
        for (int i = 0; i < 4; i++) begin
            s1616[i] = SAD16X16_W'(s816[(i/2)*4 + 2*(i%2)]) + SAD16X16_W'(s816[(i/2)*4 + 2*(i%2) + 1]);
            sad16x16_d[SAD16X16_W*i +: SAD16X16_W] = s1616[i];
        end
        for (int i = 0; i < 2; i++) begin
            s1632[i] = SAD16X32_W'(s1616[i]) + SAD16X32_W'(s1616[2+i]);
            s3216[i] = SAD16X32_W'(s1616[2*i]) + SAD16X32_W'(s1616[2*i+1]);
            sad16x32_d[SAD16X32_W*i +: SAD16X32_W] = s1632[i];
            sad32x16_d[SAD16X32_W*i +: SAD16X32_W] = s3216[i];
        end
        sad32x32_d = SAD32X32_W'(s1632[0]) + SAD32X32_W'(s1632[1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LD_IDLE;
            load_idx_q <= '0;
            pe_prev_q  <= 1'b0;
            row_cnt_q  <= '0;
            col_cnt_q  <= '0;
            for (int k = 0; k < BLK; k++) begin
                cur_buf_q[k] <= '0;
                ref_buf_q[k] <= '0;
            end
            sad4x8_q <= '0; sad8x4_q <= '0; sad8x8_q <= '0; sad8x16_q <= '0;
            sad16x8_q <= '0; sad16x16_q <= '0; sad16x32_q <= '0; sad32x16_q <= '0;
            sad32x32_q <= '0;
        end else begin
            state_q    <= state_d;
            load_idx_q <= load_idx_d;
            pe_prev_q  <= pe_begin_prepare;
            row_cnt_q  <= row_cnt_d;
            col_cnt_q  <= col_cnt_d;
            cur_buf_q  <= cur_buf_d;
            ref_buf_q  <= ref_buf_d;
            sad4x8_q <= sad4x8_d; sad8x4_q <= sad8x4_d; sad8x8_q <= sad8x8_d;
            sad8x16_q <= sad8x16_d; sad16x8_q <= sad16x8_d; sad16x16_q <= sad16x16_d;
            sad16x32_q <= sad16x32_d; sad32x16_q <= sad32x16_d; sad32x32_q <= sad32x32_d;
        end
    end

    assign SAD4x8              = sad4x8_q;
    assign SAD8x4              = sad8x4_q;
    assign SAD8x8              = sad8x8_q;
    assign SAD8x16             = sad8x16_q;
    assign SAD16x8             = sad16x8_q;
    assign SAD16x16            = sad16x16_q;
    assign SAD16x32            = sad16x32_q;
    assign SAD32x16            = sad32x16_q;
    assign SAD32x32            = sad32x32_q;
    assign search_column_count = col_cnt_q;
    assign search_row_count    = row_cnt_q;
endmodule

// File: tb/tb_basic_layer_search_engine.sv
// Directed/random bench for basic_layer_search_engine with a pixel-level reference model.
module tb_basic_layer_search_engine;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] ref_input = '0;
    logic [511:0] current_64pixels = '0;
    logic         ref_begin_prepare = 1'b0;
    logic         pe_begin_prepare = 1'b0;
    logic [415:0] SAD4x8, SAD8x4;
    logic [223:0] SAD8x8;
    logic [119:0] SAD8x16, SAD16x8;
    logic [63:0]  SAD16x16;
    logic [33:0]  SAD16x32, SAD32x16;
    logic [17:0]  SAD32x32;
    logic [4:0]   search_column_count;
    logic [6:0]   search_row_count;

    basic_layer_search_engine dut (
        .clk(clk), .rst_n(rst_n), .ref_input(ref_input),
        .current_64pixels(current_64pixels), .ref_begin_prepare(ref_begin_prepare),
        .pe_begin_prepare(pe_begin_prepare), .SAD4x8(SAD4x8), .SAD8x4(SAD8x4),
        .SAD8x8(SAD8x8), .SAD8x16(SAD8x16), .SAD16x8(SAD16x8), .SAD16x16(SAD16x16),
        .SAD16x32(SAD16x32), .SAD32x16(SAD32x16), .SAD32x32(SAD32x32),
        .search_column_count(search_column_count), .search_row_count(search_row_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;

    // Model: pixel images of the current block and the reference window.
    logic [7:0] cur_m [32][32];
    logic [7:0] ref_m [32][32];
    logic [7:0] cur_s [32][32];
    logic [7:0] ref_s [32][32];
    int row_m, col_m, load_left, pair_m;
    bit pe_prev_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rect_sad(input int x0, input int y0, input int w, input int h);
        int s = 0;
        for (int y = y0; y < y0 + h; y++)
            for (int x = x0; x < x0 + w; x++)
                s += (cur_s[y][x] > ref_s[y][x]) ? int'(cur_s[y][x]) - int'(ref_s[y][x])
                                                 : int'(ref_s[y][x]) - int'(cur_s[y][x]);
        return s;
    endfunction

    task automatic model_clear();
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++) begin
                cur_m[y][x] = '0; ref_m[y][x] = '0; cur_s[y][x] = '0; ref_s[y][x] = '0;
            end
        row_m = 0; col_m = 0; load_left = 0; pair_m = 0; pe_prev_m = 1'b0;
    endtask

    // Advance model and DUT one clock; snapshot holds the pre-edge buffers the new SADs reflect.
    task automatic tick();
        cur_s = cur_m;
        ref_s = ref_m;
        if (load_left == 0 && pe_begin_prepare && !pe_prev_m) begin
            load_left = 16;
            pair_m = 0;
        end
        if (load_left > 0) begin
            for (int x = 0; x < 32; x++) begin
                cur_m[2*pair_m][x]   = current_64pixels[8*x +: 8];
                cur_m[2*pair_m+1][x] = current_64pixels[256 + 8*x +: 8];
            end
            pair_m++;
            load_left--;
        end
        pe_prev_m = pe_begin_prepare;
        if (ref_begin_prepare) begin
            for (int y = 0; y < 31; y++)
                for (int x = 0; x < 32; x++) ref_m[y][x] = ref_m[y+1][x];
            for (int x = 0; x < 32; x++) ref_m[31][x] = ref_input[8*x +: 8];
            row_m++;
            if (row_m > 95) begin
                row_m = 0;
                col_m = (col_m + 1) % 32;
            end
        end
        @(posedge clk);
        #1;
        chk("row_count", 64'(search_row_count), 64'(row_m));
        chk("col_count", 64'(search_column_count), 64'(col_m));
    endtask

    task automatic check_sads();
        for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++)
            chk($sformatf("sad4x8[%0d]", r*8+c), 64'(SAD4x8[13*(r*8+c) +: 13]), 64'(rect_sad(4*c, 8*r, 4, 8)));
        for (int r = 0; r < 8; r++) for (int c = 0; c < 4; c++)
            chk($sformatf("sad8x4[%0d]", r*4+c), 64'(SAD8x4[13*(r*4+c) +: 13]), 64'(rect_sad(8*c, 4*r, 8, 4)));
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++)
            chk($sformatf("sad8x8[%0d]", r*4+c), 64'(SAD8x8[14*(r*4+c) +: 14]), 64'(rect_sad(8*c, 8*r, 8, 8)));
        for (int r = 0; r < 2; r++) for (int c = 0; c < 4; c++)
            chk($sformatf("sad8x16[%0d]", r*4+c), 64'(SAD8x16[15*(r*4+c) +: 15]), 64'(rect_sad(8*c, 16*r, 8, 16)));
        for (int r = 0; r < 4; r++) for (int c = 0; c < 2; c++)
            chk($sformatf("sad16x8[%0d]", r*2+c), 64'(SAD16x8[15*(r*2+c) +: 15]), 64'(rect_sad(16*c, 8*r, 16, 8)));
        for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++)
            chk($sformatf("sad16x16[%0d]", r*2+c), 64'(SAD16x16[16*(r*2+c) +: 16]), 64'(rect_sad(16*c, 16*r, 16, 16)));
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("sad16x32[%0d]", i), 64'(SAD16x32[17*i +: 17]), 64'(rect_sad(16*i, 0, 16, 32)));
            chk($sformatf("sad32x16[%0d]", i), 64'(SAD32x16[17*i +: 17]), 64'(rect_sad(0, 16*i, 32, 16)));
        end
        chk("sad32x32", 64'(SAD32x32), 64'(rect_sad(0, 0, 32, 32)));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_4x8"},   64'(SAD4x8 != '0),   64'(0));
        chk({tag, "_8x4"},   64'(SAD8x4 != '0),   64'(0));
        chk({tag, "_8x8"},   64'(SAD8x8 != '0),   64'(0));
        chk({tag, "_8x16"},  64'(SAD8x16 != '0),  64'(0));
        chk({tag, "_16x8"},  64'(SAD16x8 != '0),  64'(0));
        chk({tag, "_16x16"}, 64'(SAD16x16),       64'(0));
        chk({tag, "_16x32"}, 64'(SAD16x32),       64'(0));
        chk({tag, "_32x16"}, 64'(SAD32x16),       64'(0));
        chk({tag, "_32x32"}, 64'(SAD32x32),       64'(0));
        chk({tag, "_row"},   64'(search_row_count),    64'(0));
        chk({tag, "_col"},   64'(search_column_count), 64'(0));
    endtask

    // Asserts reset away from the clock edge and checks the asynchronous clear at once.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all_zero(tag);
        pe_begin_prepare = 1'b0;
        ref_begin_prepare = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < 8; i++) ref_input[32*i +: 32] = $urandom;
        for (int i = 0; i < 16; i++) current_64pixels[32*i +: 32] = $urandom;
    endtask

    initial begin
        model_clear();
        do_reset("reset");

        // Uniform data: every absolute difference is 0x20.
        ref_input = {32{8'h55}};
        current_64pixels = {64{8'h35}};
        ref_begin_prepare = 1'b1;
        for (int t = 0; t < 40; t++) begin
            pe_begin_prepare = (t >= 10 && t < 13);
            tick();
        end
        for (int b = 0; b < 32; b++) begin
            chk($sformatf("u_4x8[%0d]", b), 64'(SAD4x8[13*b +: 13]), 64'(1024));
            chk($sformatf("u_8x4[%0d]", b), 64'(SAD8x4[13*b +: 13]), 64'(1024));
        end
        for (int b = 0; b < 16; b++) chk($sformatf("u_8x8[%0d]", b), 64'(SAD8x8[14*b +: 14]), 64'(2048));
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("u_8x16[%0d]", b), 64'(SAD8x16[15*b +: 15]), 64'(4096));
            chk($sformatf("u_16x8[%0d]", b), 64'(SAD16x8[15*b +: 15]), 64'(4096));
        end
        for (int b = 0; b < 4; b++) chk($sformatf("u_16x16[%0d]", b), 64'(SAD16x16[16*b +: 16]), 64'(8192));
        for (int b = 0; b < 2; b++) begin
            chk($sformatf("u_16x32[%0d]", b), 64'(SAD16x32[17*b +: 17]), 64'(16384));
            chk($sformatf("u_32x16[%0d]", b), 64'(SAD32x16[17*b +: 17]), 64'(16384));
        end
        chk("u_32x32", 64'(SAD32x32), 64'(32768));

        // Enable gating: window and counters frozen while new rows are offered.
        ref_begin_prepare = 1'b0;
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 8; i++) ref_input[32*i +: 32] = $urandom;
            tick();
            chk("gate_row", 64'(search_row_count), 64'(40));
            chk("gate_32x32", 64'(SAD32x32), 64'(32768));
        end
        check_sads();

        // Random data with a second rising edge at load cycle 5 that must be ignored.
        do_reset("rst_b");
        ref_begin_prepare = 1'b1;
        for (int t = 0; t < 50; t++) begin
            randomize_inputs();
            pe_begin_prepare = (t == 2 || t == 7 || t == 8);
            tick();
            if (t == 12 || t == 49) check_sads();
        end

        // Reset in the middle of a load; loading must not resume afterwards.
        pe_begin_prepare = 1'b1;
        randomize_inputs();
        tick();
        pe_begin_prepare = 1'b0;
        for (int t = 0; t < 3; t++) begin randomize_inputs(); tick(); end
        do_reset("rst_mid");
        ref_begin_prepare = 1'b1;
        for (int t = 0; t < 20; t++) begin randomize_inputs(); tick(); end
        check_sads();

        // Positional packing: only 4x4 block at band 0, column 7 differs.
        do_reset("rst_pos");
        ref_input = '0;
        current_64pixels = {32'hFFFF_FFFF, 224'd0, 32'hFFFF_FFFF, 224'd0};
        pe_begin_prepare = 1'b1;
        tick();
        pe_begin_prepare = 1'b0;
        tick();
        current_64pixels = '0;
        for (int t = 0; t < 15; t++) tick();
        chk("pos_4x8[7]", 64'(SAD4x8[13*7 +: 13]), 64'(4080));
        chk("pos_8x4[3]", 64'(SAD8x4[13*3 +: 13]), 64'(4080));
        chk("pos_8x8[3]", 64'(SAD8x8[14*3 +: 14]), 64'(4080));
        chk("pos_32x32", 64'(SAD32x32), 64'(4080));
        for (int b = 0; b < 32; b++)
            if (b != 7) chk($sformatf("pos_4x8[%0d]", b), 64'(SAD4x8[13*b +: 13]), 64'(0));
        check_sads();

        // Counter wrap: one column per 96 rows, 32 columns per full sweep.
        do_reset("rst_cnt");
        ref_begin_prepare = 1'b1;
        for (int t = 0; t < 96; t++) begin
            for (int i = 0; i < 8; i++) ref_input[32*i +: 32] = $urandom;
            tick();
        end
        chk("wrap_row", 64'(search_row_count), 64'(0));
        chk("wrap_col", 64'(search_column_count), 64'(1));
        for (int t = 96; t < 96*32; t++) begin
            for (int i = 0; i < 8; i++) ref_input[32*i +: 32] = $urandom;
            tick();
        end
        chk("sweep_row", 64'(search_row_count), 64'(0));
        chk("sweep_col", 64'(search_column_count), 64'(0));
        check_sads();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/basic_layer_search_engine.md
# basic_layer_search_engine

Basic-layer integer motion-estimation engine for the HEVC ME datapath. It holds one 32x32 current block and streams a reference search window row by row. Every cycle it produces registered SADs for all HEVC-style sub-partitions (4x8 up to 32x32) of the current block against the 32x32 reference candidate currently in its window buffer. It also reports the search position counters.

## Interface
- No parameters. Pixel width 8 bits and block size 32x32 are fixed constants.
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ref_input  in  256  one 32-pixel reference row; pixel i at [8i+7:8i]
- current_64pixels  in  512  two current rows; bits [255:0] = even row, [511:256] = odd row, pixel i of each at [8i+7:8i]
- ref_begin_prepare  in  1  level enable: capture ref_input and advance search counters
- pe_begin_prepare  in  1  rising edge starts 16-cycle current-block load
- SAD4x8  out  416  32 x 13-bit, width 4 x height 8, index b = r*8+c (r 0..3, c 0..7), bits [13b+12:13b]
- SAD8x4  out  416  32 x 13-bit, index r*4+c (r 0..7, c 0..3)
- SAD8x8  out  224  16 x 14-bit, index r*4+c
- SAD8x16  out  120  8 x 15-bit, index r*4+c (r 0..1)
- SAD16x8  out  120  8 x 15-bit, index r*2+c (r 0..3)
- SAD16x16  out  64  4 x 16-bit, index r*2+c
- SAD16x32  out  34  2 x 17-bit, index c
- SAD32x16  out  34  2 x 17-bit, index r
- SAD32x32  out  18  1 x 18-bit
- search_column_count  out  5  horizontal candidate index 0..31
- search_row_count  out  7  rows captured in current column, 0..95

## Operation
- Reset: cur_buf, ref_buf, counters, load FSM and all SAD outputs are 0.
- Current load FSM (IDLE/LOAD):
  - IDLE -> LOAD on pe_begin_prepare high with its previous-cycle sample low. That first cycle already captures pair 0.
  - LOAD captures current_64pixels into rows 2k/2k+1 for k = 0..15 on 16 consecutive cycles, then returns to IDLE.
  - Edges during LOAD are ignored.
  - pe_begin_prepare held high re-triggers nothing.
- Reference window: 32-row shift register, ref_buf[0] = top (oldest) row.
  - On each cycle with ref_begin_prepare high: ref_buf[k] <= ref_buf[k+1], ref_buf[31] <= ref_input.
  - When ref_begin_prepare is low, ref_buf and counters hold.
- Counters, when enabled:
  - search_row_count increments 0..95 and wraps to 0.
  - On that wrap, search_column_count increments 0..31 and wraps to 0.
- SAD datapath:
  - 1024 absolute differences |cur[y][x] - ref_buf[y][x]| are summed into 64 4x4 SADs (12 bit).
  - Those are combined hierarchically: 4x8 = vertical pair of 4x4, 8x4 = horizontal pair, 8x8 = two 4x8, 8x16/16x8 from 8x8, 16x16, 16x32/32x16, 32x32.
  - Widths grow one bit per doubling, so there is no overflow or saturation.
- All SAD outputs are registered and update every cycle, including when ref_begin_prepare is low. They are also computed during load, against whatever cur_buf holds.

## Timing
- SAD outputs at cycle t+1 reflect cur_buf/ref_buf contents after edge t. Latency is 1 cycle from buffer update.
- A candidate is valid when its SAD was computed with 32 rows captured in the current column, i.e. the pre-edge search_row_count >= 32.
- The vertical candidate offset is (rows captured - 32), giving 64 vertical candidates (0..63) per column.
- Current block is complete 16 cycles after the pe_begin_prepare rising edge. The first fully valid SAD follows one cycle later.
- Counters and SADs are independent of load completion; the system controller sequences the two.
- Async reset mid-operation clears everything immediately. Load restarts only on a new rising edge after reset release.

## Structure
- Shared package `me_pkg`:
  - PIXEL_W = 8, BLK = 32
  - SAD width constants: SAD4X4_W = 12 through SAD32X32_W = 18
  - ROW_MAX = 95, COL_MAX = 31
- One sub-module `sad4x4_pe`: 16 pixel pairs in, registered-free 12-bit SAD out, instantiated 64x via generate.
- The top level holds the FSM, buffers, combining tree and output registers.

## Test plan
- Reset: hold rst_n low -> all SAD outputs and both counters read 0.
- Uniform data: ref_input all 0x55 with ref_begin_prepare high from cycle 1; pe_begin_prepare high at cycle 11 with current all 0x35. After 32 ref rows and 16 load cycles, every SAD4x8/8x4 field = 1024, 8x8 = 2048, 8x16/16x8 = 4096, 16x16 = 8192, 16x32/32x16 = 16384, SAD32x32 = 32768.
- Counter wrap: 96 enabled cycles -> row_count returns to 0 and column_count = 1. After 96*32 cycles column_count = 0.
- Enable gating: drop ref_begin_prepare for 10 cycles -> counters and SADs frozen.
- Positional packing: current = 0 except 4x4 block (row 0, col 7) = 0xFF, ref = 0 -> SAD4x8[7] = 4080, SAD8x4[3] = 4080, SAD8x8[3] = 4080, SAD32x32 = 4080, all other 4x8 fields 0.
- Load re-trigger: pulse pe_begin_prepare again at load cycle 5 -> ignored; exactly 16 row-pairs loaded.
